matmul_compute_sequencer: RTL and testbench
===========================================

Name: matmul_compute_sequencer

Overview:
Sequences the compute phase of the matrix-multiply IP once both operand matrices are resident in the storage unit. For each row of A, it steps through the B column groups (NUM_PE columns per group). For each group it issues the storage read, fires the shared PE valid, waits a fixed PE latency, then writes the NUM_PE results into the output cache. After each completed row it hands the cache to the AXI output stage and waits for that stage to drain it before starting the next row.

Parameters:
MATSIZE, 16, matrix dimension; must be divisible by NUM_PE
NUM_PE, 4, vector multipliers working in parallel on one column group
PE_LATENCY, 3, cycles from pe_valid to valid PE result; must be ≥1
ROW_W, $clog2(MATSIZE), width of row index
GRP_W, $clog2(MATSIZE/NUM_PE) (minimum 1), width of column-group index

Ports:
Clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse from the load controller: A and B are fully loaded
busy  out  1  high from acceptance of start until the done pulse, inclusive
done  out  1  one-cycle pulse when the last row has been acknowledged
rd_en  out  1  storage read enable; A row and B column group are presented next cycle
row_addr  out  ROW_W  current A row index
col_grp  out  GRP_W  current B column-group index
pe_valid  out  1  one-cycle pulse to all PEs: operands are valid
cache_we  out  1  write the NUM_PE PE outputs into the output cache
cache_addr  out  GRP_W  cache slot; PE i result goes to column col_grp*NUM_PE+i
row_ready  out  1  output cache holds a complete result row
row_ack  in  1  AXI output stage has drained the row

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; row and group counters = 0; latency counter = 0.
- Output values in reset: busy, done, rd_en, pe_valid, cache_we and row_ready are 0; row_addr, col_grp and cache_addr are 0.
- Reset asserted mid-operation aborts immediately; no further strobes; the next start begins again from row 0.
- States: IDLE, ISSUE, WAIT, WRITE, DRAIN, DONE.
- IDLE: on start, go to ISSUE with row=0 and grp=0.
- ISSUE (1 cycle): rd_en=1; go to WAIT with the latency counter cleared.
- WAIT (exactly PE_LATENCY cycles): pe_valid=1 in the first WAIT cycle only; the latency counter increments each cycle; at PE_LATENCY-1, go to WRITE.
- WRITE (1 cycle): cache_we=1 with cache_addr=grp.
  - If grp < MATSIZE/NUM_PE-1: grp++ and go to ISSUE.
  - Otherwise go to DRAIN.
- DRAIN: row_ready=1 (registered, held steady) until row_ack is sampled high.
  - On row_ack with row < MATSIZE-1: row++, grp=0, go to ISSUE.
  - On row_ack with row = MATSIZE-1: go to DONE.
- DONE (1 cycle): done=1; return to IDLE.
- busy=1 in every state except IDLE.
- Per-group cost is PE_LATENCY+2 cycles; per-row compute cost is (MATSIZE/NUM_PE)*(PE_LATENCY+2) cycles plus the DRAIN wait.
- row_addr and col_grp stay stable from ISSUE through WRITE of each group.
- start while busy: ignored, not queued.
- start and row_ack sampled in the same DRAIN cycle: row_ack is honoured, start is ignored.
- row_ack outside DRAIN: ignored.
- row_ack held high across several cycles: at most one row advance per DRAIN entry. The DRAIN exit cycle consumes the ack.
- Counter wrap: both counters return to 0 only via the explicit transitions above, never by overflow.
- MATSIZE == NUM_PE (a single group): every WRITE goes directly to DRAIN.

Test Plan:
1. Defaults (MATSIZE=16, NUM_PE=4, PE_LATENCY=3); rst pulsed; start at cycle 0; row_ack tied 1 → rd_en at cycles 1, 6, 11, 16 with col_grp 0..3. pe_valid one cycle after each rd_en. cache_we at cycles 5, 10, 15, 20 with cache_addr 0..3. row_ready at cycle 21. After 16 rows, done pulses once and busy drops the next cycle.
2. Hold row_ack low for 10 cycles in DRAIN of row 0 → row_ready stays 1 and no rd_en is issued. On the row_ack cycle the sequencer goes to ISSUE with row_addr=1, col_grp=0.
3. Pulse start while busy, including in the same cycle as row_ack during DRAIN → no restart; the row sequence is unchanged; exactly one done pulse in total.
4. Assert rst during WAIT of row 5, group 2 → all strobes go to 0 immediately and busy=0. A new start issues row_addr=0, col_grp=0.
5. Hold row_ack high continuously from before start → each row advances exactly once; 16 row_ready entries and 64 cache_we pulses in total.
6. MATSIZE=4, NUM_PE=4, PE_LATENCY=1 → per row: rd_en, then pe_valid, then cache_we (addr 0), then row_ready. done follows the 4th ack.

Source files
------------

// File: rtl/matmul_compute_sequencer_if.sv
// ---------------------------------------------------------------------------
// matmul_compute_sequencer_if
// Handshake and strobe bundle between the matrix-multiply compute sequencer
// and its neighbours (load controller, storage, PE array, output cache,
// AXI output stage).
//
// Signals:
//   start       load controller -> sequencer : operands resident, begin
//   busy        sequencer -> load controller : compute phase in progress
//   done        sequencer -> load controller : one-cycle completion pulse
//   rd_en       sequencer -> storage         : read A row / B column group
//   row_addr    sequencer -> storage         : current A row index
//   col_grp     sequencer -> storage         : current B column-group index
//   pe_valid    sequencer -> PE array        : operands valid this cycle
//   cache_we    sequencer -> output cache    : store NUM_PE PE results
//   cache_addr  sequencer -> output cache    : slot for the stored results
//   row_ready   sequencer -> AXI output      : cache holds a complete row
//   row_ack     AXI output -> sequencer      : row has been drained
//
// Modports: master = sequencer side, slave = environment side.
// ---------------------------------------------------------------------------
interface matmul_compute_sequencer_if #(
    parameter int ROW_W = 4,
    parameter int GRP_W = 2
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [ROW_W-1:0] row_addr;
    logic [GRP_W-1:0] col_grp;
    logic             pe_valid;
    logic             cache_we;
    logic [GRP_W-1:0] cache_addr;
    logic             row_ready;
    logic             row_ack;

    modport master (
        input  start, row_ack,
        output busy, done, rd_en, row_addr, col_grp,
               pe_valid, cache_we, cache_addr, row_ready
    );

    modport slave (
        output start, row_ack,
        input  busy, done, rd_en, row_addr, col_grp,
               pe_valid, cache_we, cache_addr, row_ready
    );
endinterface

// File: rtl/matmul_compute_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_compute_sequencer
// Drives the compute phase of the matrix-multiply IP. For every A row it walks
// the B column groups (NUM_PE columns each): read operands, fire pe_valid,
// wait PE_LATENCY cycles, write the NUM_PE results into the output cache.
// After the last group of a row it raises row_ready and waits for row_ack
// from the AXI output stage before moving to the next row. After the last
// row is acknowledged it pulses done.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - matmul_compute_sequencer_if.master (see interface header)
//
// All outputs are registered: each strobe is loaded from the next-state
// decode so it is high exactly in the cycle the FSM sits in that state.
// ---------------------------------------------------------------------------
module matmul_compute_sequencer #(
    parameter int MATSIZE    = 16,
    parameter int NUM_PE     = 4,
    parameter int PE_LATENCY = 3,
    parameter int ROW_W      = $clog2(MATSIZE),
    parameter int GRP_W      = ((MATSIZE / NUM_PE) > 1) ? $clog2(MATSIZE / NUM_PE) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    matmul_compute_sequencer_if.master    bus
);

    localparam int NUM_GRP = MATSIZE / NUM_PE;
    localparam int LAT_W   = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATSIZE - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GRP - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [ROW_W-1:0] row_r, row_s;
    logic [GRP_W-1:0] grp_r, grp_s;
    logic [LAT_W-1:0] lat_r, lat_s;

    logic busy_r, done_r, rd_en_r, pe_valid_r, cache_we_r, row_ready_r;
    logic busy_s, done_s, rd_en_s, pe_valid_s, cache_we_s, row_ready_s;

    // Next-state, counter and strobe decode.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        grp_s   = grp_r;
        lat_s   = lat_r;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = ISSUE;
                    row_s   = '0;
                    grp_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
                lat_s   = '0;
            end
            WAIT: begin
                if (lat_r == LAT_LAST) begin
                    state_s = WRITE;
                end else begin
                    lat_s = lat_r + LAT_W'(1);
                end
            end
            WRITE: begin
                // grp never exceeds GRP_LAST, so inequality means "more groups"
                if (grp_r != GRP_LAST) begin
                    grp_s   = grp_r + GRP_W'(1);
                    state_s = ISSUE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DRAIN: begin
                // Leaving DRAIN consumes the ack; a held ack cannot double-advance
                if (bus.row_ack) begin
                    if (row_r == ROW_LAST) begin
                        state_s = DONE;
                    end else begin
                        row_s   = row_r + ROW_W'(1);
                        grp_s   = '0;
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Strobes are registered from the state being entered
        busy_s      = (state_s != IDLE);
        done_s      = (state_s == DONE);
        rd_en_s     = (state_s == ISSUE);
        pe_valid_s  = (state_r == ISSUE);   // entering the first WAIT cycle
        cache_we_s  = (state_s == WRITE);
        row_ready_s = (state_s == DRAIN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            row_r       <= '0;
            grp_r       <= '0;
            lat_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            pe_valid_r  <= 1'b0;
            cache_we_r  <= 1'b0;
            row_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_r       <= row_s;
            grp_r       <= grp_s;
            lat_r       <= lat_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            rd_en_r     <= rd_en_s;
            pe_valid_r  <= pe_valid_s;
            cache_we_r  <= cache_we_s;
            row_ready_r <= row_ready_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.rd_en      = rd_en_r;
    assign bus.pe_valid   = pe_valid_r;
    assign bus.cache_we   = cache_we_r;
    assign bus.row_ready  = row_ready_r;
    assign bus.row_addr   = row_r;
    assign bus.col_grp    = grp_r;
    assign bus.cache_addr = grp_r;

endmodule

// File: tb/tb_matmul_compute_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_compute_sequencer
// Two sequencer instances: the default configuration (16/4/3) and a single
// group configuration (4/4/1). A timeline model (mode + offset into the row's
// compute window) predicts every output every cycle; directed sequences add
// hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_matmul_compute_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_COMP  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        int mode;
        int row;
        int k;     // offset into the row's compute window
        int grp;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;

    matmul_compute_sequencer_if #(.ROW_W(4), .GRP_W(2)) ifb ();
    matmul_compute_sequencer_if #(.ROW_W(2), .GRP_W(1)) ifs ();

    matmul_compute_sequencer #(.MATSIZE(16), .NUM_PE(4), .PE_LATENCY(3)) dut_big (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    matmul_compute_sequencer #(.MATSIZE(4), .NUM_PE(4), .PE_LATENCY(1)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    mdl_t mb, ms;
    int done_cnt, we_cnt, rd_cnt, rr_rise;
    logic rr_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Row timeline: each group occupies PE_LATENCY+2 cycles of the window.
    function automatic mdl_t step(mdl_t s, int msz, int npe, int lat,
                                  logic r, logic st, logic ack);
        mdl_t n;
        int   win;
        n   = s;
        win = (msz / npe) * (lat + 2);
        if (r) begin
            n = '0;
        end else begin
            case (s.mode)
                M_IDLE: if (st) begin
                    n.mode = M_COMP; n.row = 0; n.k = 0; n.grp = 0;
                end
                M_COMP: if (s.k == win - 1) begin
                    n.mode = M_DRAIN;
                end else begin
                    n.k   = s.k + 1;
                    n.grp = (s.k + 1) / (lat + 2);
                end
                M_DRAIN: if (ack) begin
                    if (s.row == msz - 1) n.mode = M_DONE;
                    else begin
                        n.mode = M_COMP; n.row = s.row + 1; n.k = 0; n.grp = 0;
                    end
                end
                default: n.mode = M_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] expv(mdl_t s, int lat);
        int   ph;
        logic comp;
        ph   = s.k % (lat + 2);
        comp = (s.mode == M_COMP);
        return {8'(s.grp), 8'(s.grp), 8'(s.row), 2'b00,
                (s.mode != M_IDLE), (s.mode == M_DONE),
                comp && (ph == 0), comp && (ph == 1), comp && (ph == lat + 1),
                (s.mode == M_DRAIN)};
    endfunction

    // One clock: advance both models on the edge, then compare every output.
    task automatic tick();
        logic [31:0] ab, as;
        @(posedge clk);
        mb = step(mb, 16, 4, 3, rst, ifb.start, ifb.row_ack);
        ms = step(ms, 4, 4, 1, rst, ifs.start, ifs.row_ack);
        #1;
        ab = {8'(ifb.cache_addr), 8'(ifb.col_grp), 8'(ifb.row_addr), 2'b00,
              ifb.busy, ifb.done, ifb.rd_en, ifb.pe_valid, ifb.cache_we, ifb.row_ready};
        as = {8'(ifs.cache_addr), 8'(ifs.col_grp), 8'(ifs.row_addr), 2'b00,
              ifs.busy, ifs.done, ifs.rd_en, ifs.pe_valid, ifs.cache_we, ifs.row_ready};
        chk("cycle_big", ab, expv(mb, 3));
        chk("cycle_small", as, expv(ms, 1));
        if (ifb.done === 1'b1) done_cnt++;
        if (ifb.cache_we === 1'b1) we_cnt++;
        if (ifb.rd_en === 1'b1) rd_cnt++;
        if (ifb.row_ready === 1'b1 && rr_prev !== 1'b1) rr_rise++;
        rr_prev = ifb.row_ready;
    endtask

    task automatic clr_counts();
        done_cnt = 0; we_cnt = 0; rd_cnt = 0; rr_rise = 0;
    endtask

    initial begin
        int done_cyc;
        int n;
        int hold_rd, hold_rr_low;
        logic busy_after;

        mb = '0; ms = '0; rr_prev = 1'b0;
        rst = 1'b1;
        ifb.start = 1'b0; ifb.row_ack = 1'b0;
        ifs.start = 1'b0; ifs.row_ack = 1'b0;
        clr_counts();
        tick(); tick();
        chk("reset_busy", 32'(ifb.busy), 32'd0);
        chk("reset_row_addr", 32'(ifb.row_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Full run with row_ack held high from before start
        ifb.row_ack = 1'b1;
        ifb.start   = 1'b1;
        clr_counts();
        done_cyc   = -1;
        busy_after = 1'b1;
        for (int c = 1; c <= 345; c++) begin
            tick();
            ifb.start = 1'b0;
            if (c == 1)  begin chk("t1_rd_c1", 32'(ifb.rd_en), 32'd1); chk("t1_grp_c1", 32'(ifb.col_grp), 32'd0); end
            if (c == 2)  chk("t1_pv_c2", 32'(ifb.pe_valid), 32'd1);
            if (c == 5)  begin chk("t1_we_c5", 32'(ifb.cache_we), 32'd1); chk("t1_addr_c5", 32'(ifb.cache_addr), 32'd0); end
            if (c == 6)  begin chk("t1_rd_c6", 32'(ifb.rd_en), 32'd1); chk("t1_grp_c6", 32'(ifb.col_grp), 32'd1); end
            if (c == 20) begin chk("t1_we_c20", 32'(ifb.cache_we), 32'd1); chk("t1_addr_c20", 32'(ifb.cache_addr), 32'd3); end
            if (c == 21) chk("t1_rr_c21", 32'(ifb.row_ready), 32'd1);
            if (ifb.done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = ifb.busy;
        end
        chk("t1_done_cycle", 32'(done_cyc), 32'd337);
        chk("t1_done_count", 32'(done_cnt), 32'd1);
        chk("t1_busy_after_done", 32'(busy_after), 32'd0);
        chk("t5_cache_we_count", 32'(we_cnt), 32'd64);
        chk("t5_rd_en_count", 32'(rd_cnt), 32'd64);
        chk("t5_row_ready_entries", 32'(rr_rise), 32'd16);

        // Hold row_ack low in DRAIN of row 0
        ifb.row_ack = 1'b0;
        ifb.start   = 1'b1;
        clr_counts();
        tick();
        ifb.start = 1'b0;
        repeat (20) tick();
        chk("t2_rr_enter", 32'(ifb.row_ready), 32'd1);
        hold_rd = 0; hold_rr_low = 0;
        repeat (10) begin
            tick();
            if (ifb.rd_en !== 1'b0) hold_rd++;
            if (ifb.row_ready !== 1'b1) hold_rr_low++;
        end
        chk("t2_hold_no_rd", 32'(hold_rd), 32'd0);
        chk("t2_hold_rr_steady", 32'(hold_rr_low), 32'd0);
        ifb.row_ack = 1'b1;
        tick();
        ifb.row_ack = 1'b0;
        chk("t2_adv_rd", 32'(ifb.rd_en), 32'd1);
        chk("t2_adv_row", 32'(ifb.row_addr), 32'd1);
        chk("t2_adv_grp", 32'(ifb.col_grp), 32'd0);

        // start while busy, then start together with row_ack in DRAIN
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        n = 0;
        while (ifb.row_ready !== 1'b1 && n < 40) begin tick(); n++; end
        if (n >= 40) chk("t3_drain_timeout", 32'd0, 32'd1);
        ifb.start   = 1'b1;
        ifb.row_ack = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("t3_ack_rd", 32'(ifb.rd_en), 32'd1);
        chk("t3_ack_row", 32'(ifb.row_addr), 32'd2);
        n = 0;
        while (ifb.done !== 1'b1 && n < 400) begin tick(); n++; end
        if (n >= 400) chk("t3_done_timeout", 32'd0, 32'd1);
        repeat (5) tick();
        chk("t3_single_done", 32'(done_cnt), 32'd1);
        chk("t3_idle_after", 32'(ifb.busy), 32'd0);

        // Reset during WAIT of row 5, group 2
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        n = 0;
        while (!(ifb.pe_valid === 1'b1 && ifb.row_addr == 4'd5 && ifb.col_grp == 2'd2) && n < 400) begin
            tick(); n++;
        end
        if (n >= 400) chk("t4_wait_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_flags", {26'd0, ifb.busy, ifb.done, ifb.rd_en, ifb.pe_valid, ifb.cache_we, ifb.row_ready}, 32'd0);
        chk("t4_rst_row", 32'(ifb.row_addr), 32'd0);
        chk("t4_rst_grp", 32'(ifb.col_grp), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("t4_restart_rd", 32'(ifb.rd_en), 32'd1);
        chk("t4_restart_row", 32'(ifb.row_addr), 32'd0);
        chk("t4_restart_grp", 32'(ifb.col_grp), 32'd0);
        n = 0;
        while (ifb.done !== 1'b1 && n < 400) begin tick(); n++; end
        if (n >= 400) chk("t4_done_timeout", 32'd0, 32'd1);
        tick();

        // Single-group configuration
        ifs.start = 1'b1;
        tick();
        ifs.start = 1'b0;
        chk("t6_rd", 32'(ifs.rd_en), 32'd1);
        tick();
        chk("t6_pv", 32'(ifs.pe_valid), 32'd1);
        tick();
        chk("t6_we", 32'(ifs.cache_we), 32'd1);
        chk("t6_addr", 32'(ifs.cache_addr), 32'd0);
        tick();
        chk("t6_rr", 32'(ifs.row_ready), 32'd1);
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (ifs.row_ready !== 1'b1 && n < 20) begin tick(); n++; end
            if (n >= 20) chk("t6_rr_timeout", 32'd0, 32'd1);
            ifs.row_ack = 1'b1;
            tick();
            ifs.row_ack = 1'b0;
            if (r < 3) begin
                chk("t6_next_rd", 32'(ifs.rd_en), 32'd1);
                chk("t6_next_row", 32'(ifs.row_addr), 32'(r + 1));
            end else begin
                chk("t6_done", 32'(ifs.done), 32'd1);
            end
        end
        tick();
        chk("t6_idle", 32'(ifs.busy), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
